multicycle_controller: RTL and testbench

- Moore FSM that sequences the shared datapath (one ALU, one unified memory port, register file, PC/IR/ALUOut/MDR registers) of the multi-cycle MIPS core, one instruction at a time.
- Supports the same ISA subset as the single-cycle decoder: lw, sw, lui, addi, addiu, andi, slti, sltiu, beq, j, jal, and R-type including sll/srl/sra/jr/jalr.
- Memory has variable latency; the FSM stalls on a ready handshake.

---
 rtl/multicycle_controller.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore FSM sequencing the shared datapath of the multi-cycle MIPS core:
//   IDLE -> IF -> ID -> EX -> (MEM) -> (WB) -> IF ...
//   Memory accesses in IF and MEM stall on the mem_ready handshake.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   OpCode       IR[31:26], valid from ID onward
//   Funct        IR[5:0]
//   mem_ready    memory completes the current access this cycle
//   state        current state: 0 IDLE, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
//   mem_req      memory access request, held until mem_ready
//   IorD         0 = PC address, 1 = ALUOut address
//   MemRead      memory read
//   MemWrite     memory write
//   IRWrite      load IR
//   PCWrite      unconditional PC load
//   PCWriteCond  PC load if ALU Zero (beq)
//   PCSrc        0 ALU result, 1 jump target, 2 rs, 3 ALUOut
//   RegWrite     register file write
//   RegDst       0 rt, 1 rd, 2 RA_REG
//   MemtoReg     0 ALUOut, 1 MDR, 2 PC (link)
//   ALUSrcA      0 PC, 1 rs, 2 shamt
//   ALUSrcB      0 rt, 1 const 4, 2 ext imm, 3 ext imm<<2
//   ALUOp        0 add, 1 sub, 2 R-type via Funct, 3 and, 4 slt, 5 sltu
//   ExtOp        0 zero-extend (andi), 1 sign-extend
//   LuOp         1 for lui
//   illegal_op   one-cycle pulse in EX for an undecoded opcode/funct
//   ra_sel       RA_REG while RegDst selects the link register, else 0
//
// Optional feature (macro PERF_COUNT_EN):
//   cycle_count  clocks spent outside IDLE (wraps modulo 2^32)
//   instr_count  instructions retired, i.e. entries into IF from EX/MEM/WB

module multicycle_controller #(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  OpCode,
    input  logic [5:0]  Funct,
    input  logic        mem_ready,
    output logic [2:0]  state,
    output logic        mem_req,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic [1:0]  PCSrc,
    output logic        RegWrite,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOp,
    output logic        ExtOp,
    output logic        LuOp,
    output logic        illegal_op,
    output logic [4:0]  ra_sel
`ifdef PERF_COUNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CL_ILLEGAL,
        CL_RALU,
        CL_SHIFT,
        CL_JR,
        CL_JALR,
        CL_IALU,
        CL_LW,
        CL_SW,
        CL_BEQ,
        CL_J,
        CL_JAL
    } instr_class_e;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_FUNC = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;
    localparam logic [2:0] ALU_SLTU = 3'd5;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    state_e       state_q;
    state_e       state_d;
    instr_class_e cls;
    logic [2:0]   ialu_op;

    // ---------------------------------------------------------------
    // Instruction decode
    // ---------------------------------------------------------------
    always_comb begin
        cls     = CL_ILLEGAL;
        ialu_op = ALU_ADD;
        case (OpCode)
            6'h00: begin
                case (Funct)
                    6'h00, 6'h02, 6'h03:                   cls = CL_SHIFT;
                    6'h08:                                 cls = CL_JR;
                    6'h09:                                 cls = CL_JALR;
                    6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B:                          cls = CL_RALU;
                    default:                               cls = CL_ILLEGAL;
                endcase
            end
            6'h02: cls = CL_J;
            6'h03: cls = CL_JAL;
            6'h04: cls = CL_BEQ;
            // lui adds the shifted immediate to rs ($zero), so it uses add
            6'h08, 6'h09, OP_LUI: begin
                cls     = CL_IALU;
                ialu_op = ALU_ADD;
            end
            6'h0A: begin
                cls     = CL_IALU;
                ialu_op = ALU_SLT;
            end
            6'h0B: begin
                cls     = CL_IALU;
                ialu_op = ALU_SLTU;
            end
            OP_ANDI: begin
                cls     = CL_IALU;
                ialu_op = ALU_AND;
            end
            6'h23:   cls = CL_LW;
            6'h2B:   cls = CL_SW;
            default: cls = CL_ILLEGAL;
        endcase
    end

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // ---------------------------------------------------------------
    // Next state and outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSrc       = 2'd0;
        RegWrite    = 1'b0;
        RegDst      = 2'd0;
        MemtoReg    = 2'd0;
        ALUSrcA     = 2'd0;
        ALUSrcB     = 2'd0;
        ALUOp       = ALU_ADD;
        ExtOp       = 1'b0;
        LuOp        = 1'b0;
        illegal_op  = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_IF;

            S_IF: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                // IR and PC+4 commit only in the cycle the fetch completes
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    state_d = S_ID;
                end
            end

            S_ID: begin
                ALUSrcB = 2'd3;
                ExtOp   = 1'b1;
                state_d = S_EX;
            end

            S_EX: begin
                state_d = S_IF;
                case (cls)
                    CL_RALU: begin
                        ALUSrcA = 2'd1;
                        ALUOp   = ALU_FUNC;
                        state_d = S_WB;
                    end
                    CL_SHIFT: begin
                        ALUSrcA = 2'd2;
                        ALUOp   = ALU_FUNC;
                        state_d = S_WB;
                    end
                    CL_IALU: begin
                        ALUSrcA = 2'd1;
                        ALUSrcB = 2'd2;
                        ALUOp   = ialu_op;
                        ExtOp   = (OpCode != OP_ANDI);
                        LuOp    = (OpCode == OP_LUI);
                        state_d = S_WB;
                    end
                    CL_LW, CL_SW: begin
                        ALUSrcA = 2'd1;
                        ALUSrcB = 2'd2;
                        ExtOp   = 1'b1;
                        state_d = S_MEM;
                    end
                    CL_BEQ: begin
                        ALUSrcA     = 2'd1;
                        ALUOp       = ALU_SUB;
                        PCWriteCond = 1'b1;
                        PCSrc       = 2'd3;
                    end
                    CL_J: begin
                        PCWrite = 1'b1;
                        PCSrc   = 2'd1;
                    end
                    CL_JAL: begin
                        PCWrite  = 1'b1;
                        PCSrc    = 2'd1;
                        RegWrite = 1'b1;
                        RegDst   = 2'd2;
                        MemtoReg = 2'd2;
                    end
                    CL_JR: begin
                        PCWrite = 1'b1;
                        PCSrc   = 2'd2;
                    end
                    CL_JALR: begin
                        PCWrite  = 1'b1;
                        PCSrc    = 2'd2;
                        RegWrite = 1'b1;
                        RegDst   = 2'd1;
                        MemtoReg = 2'd2;
                    end
                    default: illegal_op = 1'b1;
                endcase
            end

            S_MEM: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemRead  = (cls == CL_LW);
                MemWrite = (cls == CL_SW);
                if (mem_ready) begin
                    state_d = (cls == CL_LW) ? S_WB : S_IF;
                end
            end

            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = (OpCode == 6'h00) ? 2'd1 : 2'd0;
                MemtoReg = (cls == CL_LW) ? 2'd1 : 2'd0;
                state_d  = S_IF;
            end

            // encodings 6 and 7: outputs stay at their zero defaults
            default: state_d = S_IDLE;
        endcase
    end

    assign ra_sel = (RegDst == 2'd2) ? RA_REG : '0;

`ifdef PERF_COUNT_EN
    // ---------------------------------------------------------------
    // Performance counters
    // ---------------------------------------------------------------
    logic retire;

    assign retire = (state_d == S_IF) &&
                    ((state_q == S_EX) || (state_q == S_MEM) || (state_q == S_WB));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (state_q != S_IDLE) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (retire) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       PCWrite;
        logic       PCWriteCond;
        logic [1:0] PCSrc;
        logic       RegWrite;
        logic [1:0] RegDst;
        logic [1:0] MemtoReg;
        logic [1:0] ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [2:0] ALUOp;
        logic       ExtOp;
        logic       LuOp;
        logic       illegal_op;
        logic [4:0] ra_sel;
    } ctl_t;

    // instruction kinds of the reference model
    localparam int K_ILL = 0, K_RALU = 1, K_SHIFT = 2, K_JR = 3, K_JALR = 4,
                   K_IALU = 5, K_LW = 6, K_SW = 7, K_BEQ = 8, K_J = 9, K_JAL = 10;

    // architectural phase numbers as seen on the state output
    localparam int unsigned P_IDLE = 0, P_IF = 1, P_ID = 2, P_EX = 3, P_MEM = 4, P_WB = 5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       mem_ready;
    logic [2:0] state;
    logic       mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
    logic [1:0] PCSrc;
    logic       RegWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB;
    logic [2:0] ALUOp;
    logic       ExtOp, LuOp, illegal_op;
    logic [4:0] ra_sel;
`ifdef PERF_COUNT_EN
    logic [31:0] cycle_count, instr_count;
    int unsigned exp_cycles = 0, exp_instr = 0;
`endif

    ctl_t obs;
    assign obs = {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond,
                  PCSrc, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp,
                  ExtOp, LuOp, illegal_op, ra_sel};

    multicycle_controller #(.RA_REG(5'd31)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .mem_ready   (mem_ready),
        .state       (state),
        .mem_req     (mem_req),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSrc       (PCSrc),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .ExtOp       (ExtOp),
        .LuOp        (LuOp),
        .illegal_op  (illegal_op),
        .ra_sel      (ra_sel)
`ifdef PERF_COUNT_EN
        ,
        .cycle_count (cycle_count),
        .instr_count (instr_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned instr_idx = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------
    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn inside {6'h00, 6'h02, 6'h03}) return K_SHIFT;
            if (fn == 6'h08) return K_JR;
            if (fn == 6'h09) return K_JALR;
            if (fn inside {[6'h20:6'h27], 6'h2A, 6'h2B}) return K_RALU;
            return K_ILL;
        end
        if (op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F}) return K_IALU;
        if (op == 6'h23) return K_LW;
        if (op == 6'h2B) return K_SW;
        if (op == 6'h04) return K_BEQ;
        if (op == 6'h02) return K_J;
        if (op == 6'h03) return K_JAL;
        return K_ILL;
    endfunction

    function automatic ctl_t model(input int unsigned ph, input logic [5:0] op,
                                   input logic [5:0] fn, input logic rdy);
        ctl_t c;
        int   k;
        c = '0;
        k = kind_of(op, fn);
        if (ph == P_IF) begin
            c.mem_req = 1'b1; c.MemRead = 1'b1; c.ALUSrcB = 2'd1;
            c.IRWrite = rdy;  c.PCWrite = rdy;
        end else if (ph == P_ID) begin
            c.ALUSrcB = 2'd3; c.ExtOp = 1'b1;
        end else if (ph == P_EX) begin
            if (k == K_RALU || k == K_SHIFT) begin
                c.ALUSrcA = (k == K_SHIFT) ? 2'd2 : 2'd1;
                c.ALUOp   = 3'd2;
            end else if (k == K_IALU) begin
                c.ALUSrcA = 2'd1; c.ALUSrcB = 2'd2;
                c.ExtOp   = (op != 6'h0C);
                c.LuOp    = (op == 6'h0F);
                c.ALUOp   = (op == 6'h0C) ? 3'd3 : (op == 6'h0A) ? 3'd4 :
                            (op == 6'h0B) ? 3'd5 : 3'd0;
            end else if (k == K_LW || k == K_SW) begin
                c.ALUSrcA = 2'd1; c.ALUSrcB = 2'd2; c.ExtOp = 1'b1;
            end else if (k == K_BEQ) begin
                c.ALUSrcA = 2'd1; c.ALUOp = 3'd1; c.PCWriteCond = 1'b1; c.PCSrc = 2'd3;
            end else if (k == K_J || k == K_JAL) begin
                c.PCWrite = 1'b1; c.PCSrc = 2'd1;
                if (k == K_JAL) begin
                    c.RegWrite = 1'b1; c.RegDst = 2'd2; c.MemtoReg = 2'd2;
                end
            end else if (k == K_JR || k == K_JALR) begin
                c.PCWrite = 1'b1; c.PCSrc = 2'd2;
                if (k == K_JALR) begin
                    c.RegWrite = 1'b1; c.RegDst = 2'd1; c.MemtoReg = 2'd2;
                end
            end else begin
                c.illegal_op = 1'b1;
            end
        end else if (ph == P_MEM) begin
            c.mem_req = 1'b1; c.IorD = 1'b1;
            c.MemRead = (k == K_LW); c.MemWrite = (k == K_SW);
        end else if (ph == P_WB) begin
            c.RegWrite = 1'b1;
            c.RegDst   = (op == 6'h00) ? 2'd1 : 2'd0;
            c.MemtoReg = (k == K_LW) ? 2'd1 : 2'd0;
        end
        c.ra_sel = (c.RegDst == 2'd2) ? 5'd31 : 5'd0;
        return c;
    endfunction

    // ---------------------------------------------------------------
    // Stimulus helpers; every task is entered just after a falling edge
    // ---------------------------------------------------------------
    task automatic check_cycle(input int unsigned ph, input logic [5:0] op,
                               input logic [5:0] fn, input logic rdy);
        ctl_t exp_c;
        exp_c = model(ph, op, fn, rdy);
        #1;
        check_val($sformatf("i%0d op%02h fn%02h ph%0d state", instr_idx, op, fn, ph),
                  32'(state), 32'(ph));
        check_val($sformatf("i%0d op%02h fn%02h ph%0d ctl", instr_idx, op, fn, ph),
                  32'(obs), 32'(exp_c));
`ifdef PERF_COUNT_EN
        check_val($sformatf("i%0d cycle_count", instr_idx), cycle_count, exp_cycles);
        check_val($sformatf("i%0d instr_count", instr_idx), instr_count, exp_instr);
        if (ph != P_IDLE) exp_cycles++;
`endif
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int unsigned if_w, input int unsigned mem_w);
        int unsigned phases[$];
        int          k;
        int unsigned waits;
        k = kind_of(op, fn);
        phases = '{P_IF, P_ID, P_EX};
        if (k == K_LW || k == K_SW) phases.push_back(P_MEM);
        if (k == K_LW || k == K_RALU || k == K_SHIFT || k == K_IALU) phases.push_back(P_WB);
        OpCode = op;
        Funct  = fn;
        foreach (phases[p]) begin
            waits = (phases[p] == P_IF) ? if_w : (phases[p] == P_MEM) ? mem_w : 0;
            for (int unsigned w = 0; w <= waits; w++) begin
                if (phases[p] == P_IF || phases[p] == P_MEM)
                    mem_ready = (w == waits);
                else
                    mem_ready = 1'($urandom_range(0, 1));
                check_cycle(phases[p], op, fn, mem_ready);
                @(negedge clk);
            end
        end
`ifdef PERF_COUNT_EN
        exp_instr++;
`endif
        instr_idx++;
    endtask

    // table of encodings the decoder should recognise, plus a few it should not
    logic [11:0] itab [$] = '{
        {6'h00, 6'h20}, {6'h00, 6'h21}, {6'h00, 6'h22}, {6'h00, 6'h23}, {6'h00, 6'h24},
        {6'h00, 6'h25}, {6'h00, 6'h26}, {6'h00, 6'h27}, {6'h00, 6'h2A}, {6'h00, 6'h2B},
        {6'h00, 6'h00}, {6'h00, 6'h02}, {6'h00, 6'h03}, {6'h00, 6'h08}, {6'h00, 6'h09},
        {6'h00, 6'h01}, {6'h00, 6'h3F}, {6'h08, 6'h00}, {6'h09, 6'h00}, {6'h0A, 6'h00},
        {6'h0B, 6'h00}, {6'h0C, 6'h00}, {6'h0F, 6'h00}, {6'h23, 6'h00}, {6'h2B, 6'h00},
        {6'h04, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}, {6'h05, 6'h00}, {6'h0D, 6'h00},
        {6'h3F, 6'h00}, {6'h01, 6'h00}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] e;
        logic [5:0]  op, fn;

        reset_n   = 1'b0;
        mem_ready = 1'b0;
        OpCode    = 6'h00;
        Funct     = 6'h20;

        // reset held for three cycles: IDLE, all outputs zero, whatever is on IR
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            OpCode    = 6'($urandom);
            Funct     = 6'($urandom);
            mem_ready = 1'($urandom_range(0, 1));
            check_cycle(P_IDLE, OpCode, Funct, mem_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        check_cycle(P_IDLE, OpCode, Funct, mem_ready);
        @(negedge clk);

        // directed sequence
        run_instr(6'h00, 6'h20, 0, 0);   // add
        run_instr(6'h23, 6'h15, 0, 2);   // lw with two MEM wait cycles
        run_instr(6'h03, 6'h00, 0, 0);   // jal
        run_instr(6'h00, 6'h08, 0, 0);   // jr
        run_instr(6'h3F, 6'h00, 0, 0);   // illegal opcode
        run_instr(6'h2B, 6'h00, 2, 1);   // sw with fetch and store stalls
        run_instr(6'h04, 6'h11, 1, 0);   // beq

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                e  = itab[$urandom_range(0, itab.size() - 1)];
                op = e[11:6];
                fn = (op == 6'h00) ? e[5:0] : 6'($urandom);
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            run_instr(op, fn,
                      ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                      ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
        end

        // sw interrupted by reset while waiting in MEM
        OpCode = 6'h2B;
        Funct  = 6'h00;
        mem_ready = 1'b1; check_cycle(P_IF,  OpCode, Funct, 1'b1); @(negedge clk);
        mem_ready = 1'b1; check_cycle(P_ID,  OpCode, Funct, 1'b1); @(negedge clk);
        mem_ready = 1'b0; check_cycle(P_EX,  OpCode, Funct, 1'b0); @(negedge clk);
        mem_ready = 1'b0; check_cycle(P_MEM, OpCode, Funct, 1'b0);
        #2;
        reset_n = 1'b0;
`ifdef PERF_COUNT_EN
        exp_cycles = 0;
        exp_instr  = 0;
`endif
        #1;
        check_val("async reset state", 32'(state), 32'(P_IDLE));
        check_val("async reset MemWrite", 32'(MemWrite), 32'd0);
        check_val("async reset ctl", 32'(obs), 32'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        check_cycle(P_IDLE, OpCode, Funct, mem_ready);
        @(negedge clk);
        reset_n = 1'b1;
        check_cycle(P_IDLE, OpCode, Funct, mem_ready);
        @(negedge clk);
        run_instr(6'h23, 6'h00, 1, 1);   // lw after recovery
        run_instr(6'h00, 6'h09, 0, 0);   // jalr

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
